fifo_byte_shifter: RTL and testbench

Downstream consumer of the UDB datapath FIFO0 output stage.
- Pops one byte at a time from the FIFO head while enabled and the FIFO is not empty.
- Serializes each byte onto a clocked serial pair (sdo/sclk) at a programmable bit rate.
- Reports per-byte completion and keeps a running byte count, so DMA refill via the FIFO's own request logic proceeds as space frees.

---
 rtl/fifo_byte_shifter.sv | 110 +++++++++++
 tb/tb_fifo_byte_shifter.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/fifo_byte_shifter.sv
// Pulls bytes from the FIFO0 head one at a time and shifts them out on an sdo/sclk pair.
// sclk runs at a programmable half-period. Each completed byte raises byte_done and bumps bytes_sent.
module fifo_byte_shifter #(
  parameter int unsigned CLK_DIV   = 2,
  parameter bit          MSB_FIRST = 1'b1,
  parameter bit          CPOL      = 1'b0
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        fifo_empty,
  input  logic [7:0]  fifo_data,
  output logic        fifo_rd,
  output logic        sdo,
  output logic        sclk,
  output logic        busy,
  output logic        byte_done,
  output logic [15:0] bytes_sent
);

  typedef enum logic [1:0] {IDLE, FETCH, SHIFT} state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t     state;
  logic [7:0] shreg;
  logic [7:0] div_cnt;
  logic [2:0] bit_cnt;
  logic       phase;
  logic       go;
  logic [7:0] shreg_nxt;

  assign go        = enable & ~fifo_empty;
  assign shreg_nxt = MSB_FIRST ? {shreg[6:0], 1'b0} : {1'b0, shreg[7:1]};

  function automatic logic head_bit(input logic [7:0] b);
    return MSB_FIRST ? b[7] : b[0];
  endfunction

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state      <= IDLE;
      fifo_rd    <= 1'b0;
      sdo        <= 1'b0;
      sclk       <= CPOL;
      busy       <= 1'b0;
      byte_done  <= 1'b0;
      bytes_sent <= 16'd0;
      shreg      <= 8'd0;
      div_cnt    <= 8'd0;
      bit_cnt    <= 3'd0;
      phase      <= 1'b0;
    end else begin
      fifo_rd   <= 1'b0;
      byte_done <= 1'b0;
      case (state)
        IDLE: begin
          sclk <= CPOL;
          if (go) begin
            state   <= FETCH;
            fifo_rd <= 1'b1;
            busy    <= 1'b1;
          end
        end
        FETCH: begin
          // sdo is loaded straight from the head byte so the first bit is on the wire in the first SHIFT cycle
          shreg   <= fifo_data;
          sdo     <= head_bit(fifo_data);
          bit_cnt <= 3'd0;
          div_cnt <= 8'd0;
          phase   <= 1'b0;
          sclk    <= CPOL;
          state   <= SHIFT;
        end
        SHIFT: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= 8'd0;
            if (!phase) begin
              phase <= 1'b1;
              sclk  <= ~CPOL;
            end else begin
              phase   <= 1'b0;
              sclk    <= CPOL;
              shreg   <= shreg_nxt;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                // sdo keeps the last bit while idle or fetching
                byte_done  <= 1'b1;
                bytes_sent <= bytes_sent + 16'd1;
                if (go) begin
                  state   <= FETCH;
                  fifo_rd <= 1'b1;
                end else begin
                  state <= IDLE;
                  busy  <= 1'b0;
                end
              end else begin
                sdo <= head_bit(shreg_nxt);
              end
            end
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_byte_shifter.sv
// Randomized bench for fifo_byte_shifter. It drives two configurations side by side.
// A timeline reference model predicts every output in every cycle.
module tb_fifo_byte_shifter;

  localparam int DIV  [2] = '{2, 1};
  localparam bit MSBF [2] = '{1'b1, 1'b0};
  localparam bit CP   [2] = '{1'b0, 1'b1};

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        rst_n;
  logic        en   [2];
  logic        emp  [2];
  logic [7:0]  dat  [2];
  logic        rd   [2];
  logic        sdo  [2];
  logic        sclk [2];
  logic        busy [2];
  logic        bdone[2];
  logic [15:0] cnt  [2];

  fifo_byte_shifter #(.CLK_DIV(2), .MSB_FIRST(1'b1), .CPOL(1'b0)) u_d0 (
    .clock(clock), .reset_n(rst_n), .enable(en[0]), .fifo_empty(emp[0]),
    .fifo_data(dat[0]), .fifo_rd(rd[0]), .sdo(sdo[0]), .sclk(sclk[0]),
    .busy(busy[0]), .byte_done(bdone[0]), .bytes_sent(cnt[0]));

  fifo_byte_shifter #(.CLK_DIV(1), .MSB_FIRST(1'b0), .CPOL(1'b1)) u_d1 (
    .clock(clock), .reset_n(rst_n), .enable(en[1]), .fifo_empty(emp[1]),
    .fifo_data(dat[1]), .fifo_rd(rd[1]), .sdo(sdo[1]), .sclk(sclk[1]),
    .busy(busy[1]), .byte_done(bdone[1]), .bytes_sent(cnt[1]));

  logic [7:0]  q [2][$];
  bit          hold  [2];
  bit          pend  [2];
  bit          bsy_m [2];
  int          t_f   [2];
  logic [7:0]  cur   [2];
  logic [7:0]  done_b[2];
  logic [15:0] cnt_m [2];
  logic        sdo_m [2];
  logic        sclk_p[2];
  logic [7:0]  cap   [2];
  int          cyc, nchk, nerr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < 2; i++) begin
      emp[i] = hold[i] || (q[i].size() == 0);
      dat[i] = (q[i].size() != 0) ? q[i][0] : 8'h00;
    end
  endtask

  // The byte fetched at cycle t_f occupies cycles t_f+1 .. t_f+16*D on the wire.
  // The completion pulse comes at t_f+16*D+1.
  task automatic model(input int i);
    logic e_rd, e_bd, e_sclk;
    int   k, d;
    d = DIV[i]; e_rd = 1'b0; e_bd = 1'b0; e_sclk = CP[i];
    if (!rst_n) begin
      bsy_m[i] = 1'b0; cnt_m[i] = 16'd0; sdo_m[i] = 1'b0;
    end else begin
      if (bsy_m[i] && cyc == t_f[i] + 16*d + 1) begin
        e_bd = 1'b1; bsy_m[i] = 1'b0; cnt_m[i] = cnt_m[i] + 16'd1; done_b[i] = cur[i];
      end
      if (!bsy_m[i] && en[i] && !emp[i]) begin
        e_rd = 1'b1; bsy_m[i] = 1'b1; t_f[i] = cyc; cur[i] = q[i][0];
      end
      if (bsy_m[i] && cyc > t_f[i]) begin
        k = cyc - t_f[i] - 1;
        e_sclk   = ((k / d) % 2 == 1) ? !CP[i] : CP[i];
        sdo_m[i] = MSBF[i] ? cur[i][7 - k/(2*d)] : cur[i][k/(2*d)];
      end
    end
    chk($sformatf("fifo_rd%0d", i),    rd[i],    e_rd);
    chk($sformatf("busy%0d", i),       busy[i],  bsy_m[i]);
    chk($sformatf("sclk%0d", i),       sclk[i],  e_sclk);
    chk($sformatf("sdo%0d", i),        sdo[i],   sdo_m[i]);
    chk($sformatf("byte_done%0d", i),  bdone[i], e_bd);
    chk($sformatf("bytes_sent%0d", i), cnt[i],   cnt_m[i]);
    if (sclk_p[i] == CP[i] && sclk[i] == !CP[i])
      cap[i] = MSBF[i] ? {cap[i][6:0], sdo[i]} : {sdo[i], cap[i][7:1]};
    sclk_p[i] = sclk[i];
    if (e_bd) chk($sformatf("captured%0d", i), cap[i], done_b[i]);
    if (pend[i]) void'(q[i].pop_front());
    pend[i] = rd[i] && (q[i].size() != 0);
  endtask

  task automatic step();
    drive();
    @(negedge clock);
    cyc++;
    for (int i = 0; i < 2; i++) model(i);
  endtask

  task automatic wait_rd0();
    int n = 0;
    while (!rd[0] && n < 100) begin step(); n++; end
    chk("wait_fetch0", rd[0], 1'b1);
  endtask

  initial begin
    nchk = 0; nerr = 0; cyc = 0;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      en[i] = 1'b0; hold[i] = 1'b0; pend[i] = 1'b0; bsy_m[i] = 1'b0;
      t_f[i] = 0; cur[i] = 8'h00; done_b[i] = 8'h00; cnt_m[i] = 16'd0;
      sdo_m[i] = 1'b0; sclk_p[i] = CP[i]; cap[i] = 8'h00;
      q[i].push_back(8'h5A);
    end

    // reset, then idle with data present but disabled
    repeat (2) step();
    rst_n = 1'b1;
    repeat (20) step();

    // single byte on each configuration
    for (int i = 0; i < 2; i++) q[i].delete();
    q[0].push_back(8'hFF); q[1].push_back(8'h01);
    en[0] = 1'b1; en[1] = 1'b1;
    repeat (40) step();

    // back-to-back drain
    foreach (q[0][j]) ;
    q[0].push_back(8'hFF); q[0].push_back(8'h88); q[0].push_back(8'h44); q[0].push_back(8'h11);
    for (int j = 0; j < 4; j++) q[1].push_back(8'($urandom));
    repeat (150) step();

    // enable dropped mid-byte with more data pending
    q[0].push_back(8'hA5); q[0].push_back(8'hA5);
    q[1].push_back(8'hA5); q[1].push_back(8'hA5);
    wait_rd0();
    repeat (1 + 4*2*DIV[0]) step();
    en[0] = 1'b0; en[1] = 1'b0;
    repeat (60) step();

    // reset dropped mid-byte
    en[0] = 1'b1;
    wait_rd0();
    repeat (1 + 5*2*DIV[0]) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1; en[0] = 1'b0;
    repeat (10) step();
    for (int i = 0; i < 2; i++) q[i].delete();
    repeat (5) step();

    // counter wrap
    force u_d0.bytes_sent = 16'hFFFF;
    cnt_m[0] = 16'hFFFF;
    step();
    release u_d0.bytes_sent;
    step();
    q[0].push_back(8'h3C); en[0] = 1'b1;
    repeat (40) step();

    // random traffic
    for (int n = 0; n < 2000; n++) begin
      for (int i = 0; i < 2; i++) begin
        if ($urandom_range(0, 7) == 0 && q[i].size() < 6) q[i].push_back(8'($urandom));
        if ($urandom_range(0, 24) == 0) en[i] = ~en[i];
        if ($urandom_range(0, 29) == 0) hold[i] = ~hold[i];
      end
      rst_n = ($urandom_range(0, 399) != 0);
      step();
    end
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin en[i] = 1'b0; hold[i] = 1'b0; end
    repeat (40) step();

    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end

endmodule
